// File: rtl/des_round_controller_if.sv
// Handshake and datapath-control bundle between a DES datapath requester and
// the round controller.
interface des_round_controller_if;
   logic       start_valid;
   logic       start_ready;
   logic       decrypt;
   logic       ip_load;
   logic       key_load;
   logic       round_en;
   logic [3:0] round_idx;
   logic [1:0] key_shift;
   logic       key_dir;
   logic       fp_capture;
   logic       done_valid;
   logic       done_ready;
   logic       busy;

   modport master (
      output start_valid, decrypt, done_ready,
      input  start_ready, ip_load, key_load, round_en, round_idx,
             key_shift, key_dir, fp_capture, done_valid, busy
   );

   modport slave (
      input  start_valid, decrypt, done_ready,
      output start_ready, ip_load, key_load, round_en, round_idx,
             key_shift, key_dir, fp_capture, done_valid, busy
   );
endinterface

// File: rtl/des_round_controller.sv
// Sequences one DES block: IP/PC-1 load, NUM_ROUNDS Feistel rounds with the
// key-schedule rotate amounts, final permutation capture, and result handshake.
module des_round_controller #(
   parameter int unsigned NUM_ROUNDS = 16
) (
   input logic                   clk,
   input logic                   rst,
   des_round_controller_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      FINAL,
      DONE
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

   state_t     state;
   state_t     next_state;
   logic [3:0] cnt;
   logic       dir;
   logic       last_round;

   assign last_round = (cnt == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         dir   <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && bus.start_valid)
            dir <= bus.decrypt;
         if (state == ROUND && !last_round)
            cnt <= cnt + 4'd1;
         else
            cnt <= '0;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start_valid) next_state = LOAD;
         LOAD:    next_state = ROUND;
         ROUND:   if (last_round) next_state = FINAL;
         FINAL:   next_state = DONE;
         DONE:    if (bus.done_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs depend on registered state only; rst just forces them low.
   always_comb begin
      bus.start_ready = 1'b0;
      bus.ip_load     = 1'b0;
      bus.key_load    = 1'b0;
      bus.round_en    = 1'b0;
      bus.round_idx   = '0;
      bus.key_shift   = '0;
      bus.key_dir     = 1'b0;
      bus.fp_capture  = 1'b0;
      bus.done_valid  = 1'b0;
      bus.busy        = 1'b0;
      if (!rst) begin
         bus.key_dir = dir;
         bus.busy    = (state != IDLE);
         case (state)
            IDLE:  bus.start_ready = 1'b1;
            LOAD: begin
               bus.ip_load  = 1'b1;
               bus.key_load = 1'b1;
            end
            ROUND: begin
               bus.round_en  = 1'b1;
               bus.round_idx = cnt;
               // Decrypt skips the first rotate so C/D start from the unrotated key.
               case (cnt)
                  4'd0:                bus.key_shift = dir ? 2'd0 : 2'd1;
                  4'd1, 4'd8, 4'd15:   bus.key_shift = 2'd1;
                  default:             bus.key_shift = 2'd2;
               endcase
            end
            FINAL: bus.fp_capture = 1'b1;
            DONE:  bus.done_valid = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/des_round_controller.md
DES_ROUND_CONTROLLER -- requirements
Module: des_round_controller

Interface
REQ-001 Parameter NUM_ROUNDS, default 16, number of cipher rounds sequenced; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start_valid  input  1  requester has a 64-bit block and key ready in the datapath input registers.
REQ-005 start_ready  output  1  controller can accept a new block.
REQ-006 decrypt  input  1  mode, sampled only on the accept cycle: 0 encrypt, 1 decrypt.
REQ-007 ip_load  output  1  one-cycle strobe: load the initial permutation result into the L/R registers.
REQ-008 key_load  output  1  one-cycle strobe: load PC-1 of the key into the C/D registers.
REQ-009 round_en  output  1  advance one Feistel round this cycle.
REQ-010 round_idx  output  4  zero-based index of the current round.
REQ-011 key_shift  output  2  C/D rotate amount this cycle (0, 1 or 2).
REQ-012 key_dir  output  1  rotate direction: 0 left (encrypt), 1 right (decrypt).
REQ-013 fp_capture  output  1  one-cycle strobe: capture the final permutation of R16L16 into the output register.
REQ-014 done_valid  output  1  result register holds a completed block.
REQ-015 done_ready  input  1  consumer accepts the result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have five states: IDLE, LOAD, ROUND, FINAL and DONE.
REQ-018 IDLE: start_ready=1; accept = start_valid&&start_ready; on accept, latch decrypt into key_dir and go to LOAD.
REQ-019 LOAD (1 cycle): ip_load=1, key_load=1, round counter cleared to 0; next state ROUND.
REQ-020 ROUND (NUM_ROUNDS cycles): round_en=1, round_idx=counter; counter increments each cycle; after round_idx==NUM_ROUNDS-1, go to FINAL.
REQ-021 Encrypt key_shift per 1-based round r: 1 if r in {1,2,9,16}, else 2.
REQ-022 Decrypt key_shift per 1-based round r: 0 if r=1; 1 if r in {2,9,16}; else 2.
REQ-023 Outside ROUND: key_shift=0 and round_idx=0.
REQ-024 FINAL (1 cycle): fp_capture=1; next state DONE.
REQ-025 DONE: done_valid=1, held until done_valid&&done_ready; then IDLE.
REQ-026 Latency: with accept at edge T:
  - ip_load at T+1
  - rounds T+2..T+NUM_ROUNDS+1
  - fp_capture at T+NUM_ROUNDS+2
  - done_valid first high at T+NUM_ROUNDS+3 (T+19 for the default).
REQ-027 Only one block in flight.
  - start_ready=0 in LOAD/ROUND/FINAL/DONE.
  - start_valid in those states is ignored, with no queuing.
REQ-028 done_ready while done_valid=0 SHALL have no effect.
REQ-029 DONE with done_ready held high SHALL last exactly one cycle.
  - IDLE follows, so a new accept is possible one cycle after the done handshake.
REQ-030 decrypt changes after accept SHALL NOT affect key_dir or key_shift of the block in flight.
REQ-031 All strobes (ip_load, key_load, round_en, fp_capture) SHALL be mutually exclusive and decoded from registered state only, with no combinational path from inputs.

Reset
REQ-032 While rst=1 at a rising edge, the controller SHALL enter IDLE and clear the round counter and key_dir.
REQ-033 Output values while rst=1:
  - start_ready=0
  - every other output 0
  - start_ready=1 from the first cycle after rst falls.
REQ-034 rst in any state, including mid-ROUND and DONE, SHALL abort the block with no fp_capture and no done_valid; the result is discarded.

Verification
REQ-035 Encrypt: start_valid=1 one cycle, decrypt=0, done_ready=1 -> ip_load at T+1; key_shift over rounds = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with key_dir=0; fp_capture at T+18; done_valid one cycle at T+19.
REQ-036 Decrypt: same stimulus with decrypt=1, toggling decrypt to 0 at T+5 -> key_shift = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with key_dir=1 throughout.
REQ-037 Backpressure: done_ready=0 for 10 cycles after done_valid -> done_valid stays high; start_valid held high meanwhile gets no accept; accept occurs one cycle after the done handshake.
REQ-038 Reset mid-operation: rst=1 at round_idx=7 -> all outputs 0 next cycle; start_ready=1 the cycle after rst falls; no fp_capture for the aborted block.
REQ-039 Back-to-back: start_valid and done_ready held high for 3 blocks -> accepts every 20 cycles; round_idx sweeps 0..15 each block; strobes never overlap.
